// File: rtl/wave_capture_pkg.sv
// Shared state encoding, default sizes and the sample-to-display conversion
// for the wave_capture block.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_e;

    localparam int DEPTH_LOG2_DEF = 8;
    localparam int TIMEOUT_DEF    = 2048;

    // Top byte with the sign bit flipped: signed audio -> unsigned display row.
    function automatic logic [7:0] to_display(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

endpackage

// File: rtl/dffr.sv
// Flip-flop primitive with asynchronous active-high reset to zero.
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge r) begin
        if (r) q <= '0;
        else   q <= d;
    end

endmodule

// File: rtl/dffre.sv
// Flip-flop primitive with asynchronous active-high reset and load enable.
module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge r) begin
        if (r)       q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/wave_capture.sv
// Captures one frame of audio per positive zero crossing into a double-buffered
// RAM. Optional forced trigger after TIMEOUT armed samples: WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [15:0]           new_sample_in,
    input  logic                  wave_display_idle,
    output logic [DEPTH_LOG2:0]   write_address,
    output logic                  write_enable,
    output logic [7:0]            write_sample,
    output logic                  read_index
);

    state_e                state_d;
    logic [1:0]            state_q;
    logic [DEPTH_LOG2-1:0] count_d, count_q;
    logic [15:0]           prev_sample_q;
    logic                  read_index_d, read_index_q;
    logic                  write_enable_d, write_enable_q;
    logic [DEPTH_LOG2:0]   write_address_d, write_address_q;
    logic [7:0]            write_sample_d, write_sample_q;
    logic                  crossing;
    logic                  tmo_hit;
    logic                  unused_prev;

    assign crossing    = prev_sample_q[15] & ~new_sample_in[15];
    assign unused_prev = ^prev_sample_q[14:0];

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_d, tmo_q;

    always_comb begin
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        if (state_q != ARMED) begin
            tmo_d = '0;
        end else if (new_sample_ready) begin
            tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
            tmo_d   = (crossing || tmo_hit) ? '0 : tmo_q + 1'b1;
        end
    end

    dffr #(.WIDTH(TW)) u_tmo (.clk(clk), .r(reset), .d(tmo_d), .q(tmo_q));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d         = state_e'(state_q);
        count_d         = count_q;
        read_index_d    = read_index_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;
        case (state_q)
            ARMED: begin
                if (new_sample_ready && (crossing || tmo_hit)) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, {DEPTH_LOG2{1'b0}}};
                    write_sample_d  = to_display(new_sample_in);
                    count_d         = DEPTH_LOG2'(1);
                    state_d         = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, count_q};
                    write_sample_d  = to_display(new_sample_in);
                    count_d         = count_q + 1'b1;
                    if (&count_q) state_d = WAIT;
                end
            end
            WAIT: begin
                // Samples arriving here only refresh prev_sample, even on the swap cycle.
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    dffr  #(.WIDTH(2))            u_state (.clk(clk), .r(reset), .d(state_d),         .q(state_q));
    dffr  #(.WIDTH(DEPTH_LOG2))   u_count (.clk(clk), .r(reset), .d(count_d),         .q(count_q));
    dffre #(.WIDTH(16))           u_prev  (.clk(clk), .r(reset), .en(new_sample_ready),
                                           .d(new_sample_in), .q(prev_sample_q));
    dffr  #(.WIDTH(1))            u_ridx  (.clk(clk), .r(reset), .d(read_index_d),    .q(read_index_q));
    dffr  #(.WIDTH(1))            u_we    (.clk(clk), .r(reset), .d(write_enable_d),  .q(write_enable_q));
    dffr  #(.WIDTH(DEPTH_LOG2+1)) u_waddr (.clk(clk), .r(reset), .d(write_address_d), .q(write_address_q));
    dffr  #(.WIDTH(8))            u_wdata (.clk(clk), .r(reset), .d(write_sample_d),  .q(write_sample_q));

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Randomized self-checking bench for wave_capture against a frame-level
// reference model (phase / offset / half bookkeeping in plain integers).
module tb_wave_capture;

    localparam int DL    = 8;
    localparam int DEPTH = 1 << DL;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = '0;
    logic        wave_display_idle = 1'b0;
    logic [DL:0] write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 = waiting for crossing, 1 = filling frame, 2 = frame full.
    int m_phase, m_off, m_tcnt, m_prev;
    bit m_half;
    bit exp_we;
    int exp_addr, exp_data;

    always #5 clk = ~clk;

    wave_capture #(.DEPTH_LOG2(DL), .TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in),
        .wave_display_idle(wave_display_idle),
        .write_address(write_address),
        .write_enable(write_enable),
        .write_sample(write_sample),
        .read_index(read_index)
    );

    task automatic model_reset();
        m_phase = 0; m_off = 0; m_tcnt = 0; m_prev = 0; m_half = 1'b0; exp_we = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, sample after the rising edge.
    task automatic step(input bit rdy, input int s, input bit idl);
        int  v;
        bit  trig;
        @(negedge clk);
        new_sample_ready  = rdy;
        new_sample_in     = s[15:0];
        wave_display_idle = idl;
        v      = int'($signed(s[15:0]));
        exp_we = 1'b0;
        trig   = 1'b0;
        if (m_phase == 2) begin
            if (idl) begin
                m_half  = !m_half;
                m_phase = 0;
            end
        end else if (rdy) begin
            if (m_phase == 0) begin
                m_tcnt++;
                trig = (m_prev < 0) && (v >= 0);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                if (m_tcnt == TMO) trig = 1'b1;
`endif
                if (trig) begin
                    m_phase = 1; m_off = 0; m_tcnt = 0;
                end
            end
            if (m_phase == 1) begin
                exp_we   = 1'b1;
                exp_addr = (m_half ? 0 : DEPTH) + m_off;
                exp_data = (v + 32768) / 256;
                m_off++;
                if (m_off == DEPTH) m_phase = 2;
            end
        end
        if (rdy) m_prev = v;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; new_sample_ready = 1'b0; wave_display_idle = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (write_enable !== 1'b0 || write_address !== '0 || write_sample !== 8'h00 || read_index !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: we=%0b addr=%0h data=%0h ri=%0b required all 0",
                     write_enable, write_address, write_sample, read_index);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        step(1'b1, -100, 1'b0);
        checks++;
        if (write_enable !== 1'b0) begin
            failures++; $display("FAIL basic_no_write_neg: got we=%0b required 0", write_enable);
        end
        step(1'b1, 50, 1'b0);
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h80) begin
            failures++;
            $display("FAIL basic_trigger: got we=%0b addr=%0h data=%0h required 1/100/80",
                     write_enable, write_address, write_sample);
        end
        step(1'b0, 0, 1'b0);
        checks++;
        if (write_enable !== 1'b0) begin
            failures++; $display("FAIL basic_we_one_cycle: got we=%0b required 0", write_enable);
        end
    endtask

    // Continues the frame opened by test_basic: 255 more samples with random gaps.
    task automatic test_full_frame();
        int n;
        n = 0;
        while (n < DEPTH - 1) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, int'($urandom_range(0, 65535)), 1'b0);
                checks++;
                if (write_enable !== 1'b0) begin
                    failures++; $display("FAIL frame_gap_we: got we=%0b required 0", write_enable);
                end
            end else begin
                step(1'b1, int'($urandom_range(0, 65535)), 1'b0);
                n++;
                checks++;
                if (write_enable !== exp_we || write_address !== 9'(exp_addr) || write_sample !== 8'(exp_data)) begin
                    failures++;
                    $display("FAIL frame_write n=%0d: got we=%0b addr=%0h data=%0h required %0b/%0h/%0h",
                             n, write_enable, write_address, write_sample, exp_we, exp_addr, exp_data);
                end
            end
        end
        checks++;
        if (write_address !== 9'h1FF) begin
            failures++; $display("FAIL frame_last_addr: got %0h required 1ff", write_address);
        end
        step(1'b1, 1234, 1'b0);
        checks++;
        if (write_enable !== 1'b0 || m_phase != 2) begin
            failures++; $display("FAIL frame_257th: got we=%0b required 0 (model phase %0d)", write_enable, m_phase);
        end
    endtask

    task automatic test_swap();
        step(1'b0, 0, 1'b1);
        checks++;
        if (read_index !== 1'b1) begin
            failures++; $display("FAIL swap_read_index: got %0b required 1", read_index);
        end
        step(1'b1, -5, 1'b0);
        step(1'b1, 7, 1'b0);
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h000 || write_sample !== 8'(exp_data)) begin
            failures++;
            $display("FAIL swap_next_frame: got we=%0b addr=%0h data=%0h required 1/0/%0h",
                     write_enable, write_address, write_sample, exp_data);
        end
    endtask

    task automatic test_zero_cross();
        pulse_reset();
        step(1'b1, -1, 1'b0);
        step(1'b1, 0, 1'b0);
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h80) begin
            failures++;
            $display("FAIL zero_after_neg: got we=%0b addr=%0h data=%0h required 1/100/80",
                     write_enable, write_address, write_sample);
        end
        step(1'b1, 5, 1'b0);
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h101) begin
            failures++; $display("FAIL zero_follow: got we=%0b addr=%0h required 1/101", write_enable, write_address);
        end
        pulse_reset();
        step(1'b1, 0, 1'b0);
        step(1'b1, 5, 1'b0);
        checks++;
        if (write_enable !== 1'b0) begin
            failures++; $display("FAIL zero_then_pos: got we=%0b required 0", write_enable);
        end
    endtask

    task automatic test_coincident();
        pulse_reset();
        step(1'b1, -7, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 100 + i, 1'b0);
        step(1'b1, -3, 1'b0);
        step(1'b1, 9, 1'b1);
        checks++;
        if (write_enable !== 1'b0 || read_index !== 1'b1) begin
            failures++; $display("FAIL coincident_swap: got we=%0b ri=%0b required 0/1", write_enable, read_index);
        end
        step(1'b1, 9, 1'b0);
        checks++;
        if (write_enable !== 1'b0) begin
            failures++; $display("FAIL coincident_after: got we=%0b required 0", write_enable);
        end
        step(1'b1, -1, 1'b0);
        step(1'b1, 2, 1'b0);
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h000) begin
            failures++; $display("FAIL coincident_retrigger: got we=%0b addr=%0h required 1/0", write_enable, write_address);
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        step(1'b1, -2, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, int'($urandom_range(0, 65535)), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (write_enable !== 1'b0 || write_address !== '0 || write_sample !== 8'h00 || read_index !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: we=%0b addr=%0h data=%0h ri=%0b required all 0",
                     write_enable, write_address, write_sample, read_index);
        end
        @(negedge clk);
        new_sample_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b1, -300, 1'b0);
        step(1'b1, 300, 1'b0);
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h100) begin
            failures++; $display("FAIL reset_restart: got we=%0b addr=%0h required 1/100", write_enable, write_address);
        end
    endtask

    task automatic test_timeout();
        int writes;
        pulse_reset();
        writes = 0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        for (int i = 1; i <= TMO; i++) begin
            step(1'b1, 1000, 1'b0);
            if (i < TMO) begin
                checks++;
                if (write_enable !== 1'b0) begin
                    failures++; $display("FAIL timeout_early strobe=%0d: got we=%0b required 0", i, write_enable);
                end
            end
            step(1'b0, 0, 1'b0);
        end
        // The write for strobe TMO was sampled one step ago; re-drive the check from a fresh run.
        pulse_reset();
        for (int i = 1; i < TMO; i++) step(1'b1, 1000, 1'b0);
        step(1'b1, 1000, 1'b0);
        checks++;
        if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h83) begin
            failures++;
            $display("FAIL timeout_trigger: got we=%0b addr=%0h data=%0h required 1/100/83",
                     write_enable, write_address, write_sample);
        end
`else
        for (int i = 0; i < 5000; i++) begin
            step(1'b1, 1000, 1'b0);
            if (write_enable !== 1'b0) writes++;
        end
        checks++;
        if (writes != 0) begin
            failures++; $display("FAIL no_timeout: got %0d writes required 0", writes);
        end
`endif
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1) == 1), int'($urandom_range(0, 65535)), ($urandom_range(0, 7) == 0));
            checks++;
            if (write_enable !== exp_we) begin
                failures++; $display("FAIL rand_we cyc=%0d: got %0b required %0b", i, write_enable, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (write_address !== 9'(exp_addr) || write_sample !== 8'(exp_data)) begin
                    failures++;
                    $display("FAIL rand_write cyc=%0d: got addr=%0h data=%0h required %0h/%0h",
                             i, write_address, write_sample, exp_addr, exp_data);
                end
            end
            checks++;
            if (read_index !== m_half) begin
                failures++; $display("FAIL rand_read_index cyc=%0d: got %0b required %0b", i, read_index, m_half);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_full_frame();
        test_swap();
        test_zero_cross();
        test_coincident();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
